// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM state encoding, slave count and word width.
package spi_pkg;

    localparam int unsigned NumSlaves = 4;
    localparam int unsigned WordWidth = 8;
    localparam int unsigned SelWidth  = $clog2(NumSlaves);
    localparam int unsigned BitWidth  = $clog2(WordWidth);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSclkHi,
        StSclkLo,
        StGap
    } spi_state_e;

    // Active-low one-cold chip-select pattern for a slave index.
    function automatic logic [NumSlaves-1:0] cs_decode(input logic [SelWidth-1:0] sel);
        logic [NumSlaves-1:0] cs;
        cs      = '1;
        cs[sel] = 1'b0;
        return cs;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-requester grant logic with a last-granted pointer; requester 0 wins ties after reset.
// Define SPI_ARB_FIXED_PRIO_EN to make requester 0 always win simultaneous requests.
module spi_rr_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef SPI_ARB_FIXED_PRIO_EN

    always_comb begin
        gnt0_o = en_i && req0_i;
        gnt1_o = en_i && req1_i && !req0_i;
    end

`else

    logic last_q;
    logic last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (en_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = last_q;
                gnt1_o = !last_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0_o) begin
            last_d = 1'b0;
        end else if (gnt1_o) begin
            last_d = 1'b1;
        end
    end

    // Pointer resets to 1 so requester 0 is preferred first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/spi_master_arbiter.sv
// Two-requester SPI master (CPOL=0, CPHA=0, LSB-first) sharing one bus over four chip selects.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module spi_master_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_i,
    input  logic                 req1_i,
    input  logic [SelWidth-1:0]  sel0_bi,
    input  logic [SelWidth-1:0]  sel1_bi,
    input  logic [WordWidth-1:0] wdata0_bi,
    input  logic [WordWidth-1:0] wdata1_bi,
    output logic                 gnt0_o,
    output logic                 gnt1_o,
    output logic                 done0_o,
    output logic                 done1_o,
    output logic [WordWidth-1:0] rdata_bo,
    output logic                 busy_o,
    output logic                 spi_sclk_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i,
    output logic [NumSlaves-1:0] spi_cs_bo
);

    localparam logic [7:0]          DivLast = 8'(CLK_DIV - 1);
    localparam logic [BitWidth-1:0] BitLast = BitWidth'(WordWidth - 1);

    spi_state_e            state_q;
    logic [7:0]            div_q;
    logic [BitWidth-1:0]   bit_q;
    logic                  owner_q;
    logic [WordWidth-1:0]  tx_q;
    logic [WordWidth-1:0]  rx_q;
    logic [WordWidth-1:0]  rdata_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic [NumSlaves-1:0]  cs_q;
    logic                  done0_q;
    logic                  done1_q;

    logic                  arb_en;
    logic                  gnt0;
    logic                  gnt1;
    logic [SelWidth-1:0]   sel_win;
    logic [WordWidth-1:0]  wdata_win;
    logic                  div_last;

    // Gating on rst_i keeps grants low for the whole reset interval.
    assign arb_en = (state_q == StIdle) && !rst_i;

    spi_rr_arbiter u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (arb_en),
        .req0_i (req0_i),
        .req1_i (req1_i),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign sel_win   = gnt1 ? sel1_bi : sel0_bi;
    assign wdata_win = gnt1 ? wdata1_bi : wdata0_bi;
    assign div_last  = (div_q == DivLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            owner_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (state_q == StIdle) begin
                div_q <= '0;
                if (gnt0 || gnt1) begin
                    owner_q <= gnt1;
                    tx_q    <= wdata_win;
                    cs_q    <= cs_decode(sel_win);
                    sclk_q  <= 1'b0;
                    mosi_q  <= wdata_win[0];
                    bit_q   <= '0;
                    state_q <= StSetup;
                end
            end else if (!div_last) begin
                div_q <= div_q + 8'd1;
            end else begin
                div_q <= '0;
                unique case (state_q)
                    StSetup: begin
                        state_q <= StSclkHi;
                        sclk_q  <= 1'b1;
                        rx_q    <= {spi_miso_i, rx_q[WordWidth-1:1]};
                    end
                    StSclkHi: begin
                        state_q <= StSclkLo;
                        sclk_q  <= 1'b0;
                        tx_q    <= {1'b0, tx_q[WordWidth-1:1]};
                        mosi_q  <= tx_q[1];
                    end
                    StSclkLo: begin
                        // CS stays low through the last low phase so the slave finishes its shift.
                        if (bit_q == BitLast) begin
                            state_q <= StGap;
                            cs_q    <= '1;
                            mosi_q  <= 1'b0;
                            rdata_q <= rx_q;
                            done0_q <= !owner_q;
                            done1_q <= owner_q;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= StSclkHi;
                            sclk_q  <= 1'b1;
                            rx_q    <= {spi_miso_i, rx_q[WordWidth-1:1]};
                        end
                    end
                    StGap: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign gnt0_o     = gnt0;
    assign gnt1_o     = gnt1;
    assign done0_o    = done0_q;
    assign done1_o    = done1_q;
    assign rdata_bo   = rdata_q;
    assign busy_o     = (state_q != StIdle);
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_bo  = cs_q;

    cs_one_cold: assert property (@(posedge clk_i) disable iff (rst_i)
        $countones(~spi_cs_bo) <= 1);
    gnt_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(gnt0_o && gnt1_o));
    done_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(done0_o && done1_o));

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter with a CPHA=0 slave model and an arbitration model.
module tb_spi_master_arbiter;

    localparam int D = 2;
`ifdef SPI_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic       req0, req1;
    logic [1:0] sel0, sel1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, busy, sclk, mosi, miso;
    logic [7:0] rdata;
    logic [3:0] cs;

    logic       b_req0, b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_sclk, b_mosi;
    logic       b_req1 = 1'b0;
    logic       b_miso = 1'b0;
    logic [1:0] b_sel  = 2'd3;
    logic [7:0] b_wd   = 8'h5A;
    logic [7:0] b_rdata;
    logic [3:0] b_cs;

    int n_checks = 0;
    int n_pass   = 0;
    int last_m   = 1;

    always #5 clk = ~clk;

    spi_master_arbiter #(.CLK_DIV(D)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req0_i     (req0),
        .req1_i     (req1),
        .sel0_bi    (sel0),
        .sel1_bi    (sel1),
        .wdata0_bi  (wdata0),
        .wdata1_bi  (wdata1),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .done0_o    (done0),
        .done1_o    (done1),
        .rdata_bo   (rdata),
        .busy_o     (busy),
        .spi_sclk_o (sclk),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso),
        .spi_cs_bo  (cs)
    );

    spi_master_arbiter #(.CLK_DIV(1)) u_dut1 (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req0_i     (b_req0),
        .req1_i     (b_req1),
        .sel0_bi    (b_sel),
        .sel1_bi    (b_sel),
        .wdata0_bi  (b_wd),
        .wdata1_bi  (b_wd),
        .gnt0_o     (b_gnt0),
        .gnt1_o     (b_gnt1),
        .done0_o    (b_done0),
        .done1_o    (b_done1),
        .rdata_bo   (b_rdata),
        .busy_o     (b_busy),
        .spi_sclk_o (b_sclk),
        .spi_mosi_o (b_mosi),
        .spi_miso_i (b_miso),
        .spi_cs_bo  (b_cs)
    );

    // CPHA=0 slave: first bit valid when CS falls, sample on SCLK rise, shift on SCLK fall.
    logic [7:0] sl_tx = 8'h00;
    logic [7:0] sl_rx = 8'h00;
    int         sl_bit = 0;
    bit         sl_rose = 1'b0;
    logic       cs_all;
    assign cs_all = &cs;

    always @(posedge sclk or negedge sclk or cs_all) begin
        if (cs_all) begin
            sl_bit  = 0;
            sl_rose = 1'b0;
        end else if (sclk) begin
            sl_rx   = {mosi, sl_rx[7:1]};
            sl_rose = 1'b1;
        end else if (sl_rose) begin
            sl_bit  = sl_bit + 1;
            sl_rose = 1'b0;
        end
    end

    always_comb miso = cs_all ? 1'b0 : sl_tx[sl_bit[2:0]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int exp_winner(input logic r0, input logic r1);
        if (r0 && r1) return FixedPrio ? 0 : (last_m == 1 ? 0 : 1);
        return (r1 && !r0) ? 1 : 0;
    endfunction

    task automatic wait_gnt(output int who, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b1;
        who    = 0;
        #1;
        while (!(gnt0 || gnt1)) begin
            if (waited >= 100) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        who = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
    endtask

    task automatic run_xfer(input bit hold, input logic [7:0] sl_byte, output int waited);
        int         who, exp_w, k, rises;
        bit         ok, cs_ok, sel_seen, busy_ok, prev;
        logic [7:0] exp_wd, mseq;
        logic [3:0] exp_cs;
        wait_gnt(who, waited, ok);
        if (!ok) begin
            check_eq("gnt_timeout", 32'd0, 32'd1);
            return;
        end
        exp_w  = exp_winner(req0, req1);
        last_m = exp_w;
        check_eq("winner", 32'(who), 32'(exp_w));
        exp_wd = (exp_w == 1) ? wdata1 : wdata0;
        exp_cs = 4'hF & ~(4'b0001 << ((exp_w == 1) ? sel1 : sel0));
        sl_tx  = sl_byte;
        k = 0; rises = 0; prev = 1'b0; mseq = 8'h00;
        cs_ok = 1'b1; sel_seen = 1'b0; busy_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            #1;
            k++;
            if (k == 1 && !hold) begin
                // Requester drops and scribbles its inputs; the captured transfer must not change.
                if (exp_w == 1) begin req1 = 1'b0; sel1 = 2'($urandom); wdata1 = 8'($urandom); end
                else begin req0 = 1'b0; sel0 = 2'($urandom); wdata0 = 8'($urandom); end
            end
            if (sclk && !prev) begin
                if (rises < 8) mseq[rises] = mosi;
                rises++;
            end
            prev = sclk;
            if (!(cs == 4'hF || cs == exp_cs)) cs_ok = 1'b0;
            if (cs == exp_cs) sel_seen = 1'b1;
            if (!busy) busy_ok = 1'b0;
            if (done0 || done1 || k >= 200) break;
        end
        check_eq("latency", 32'(k), 32'(17 * D + 1));
        check_eq("done_owner", 32'({done1, done0}), (exp_w == 1) ? 32'd2 : 32'd1);
        check_eq("sclk_pulses", 32'(rises), 32'd8);
        check_eq("cs_legal", 32'(cs_ok), 32'd1);
        check_eq("cs_sel", 32'(sel_seen), 32'd1);
        check_eq("busy", 32'(busy_ok), 32'd1);
        check_eq("rdata", 32'(rdata), 32'(sl_byte));
        check_eq("slave_rx", 32'(sl_rx), 32'(exp_wd));
        check_eq("mosi_seq", 32'(mseq), 32'(exp_wd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, who, k, rises, d1, d2, g2, gap;
        bit ok, prev, seen_done;
        rst_i = 1'b1;
        req0 = 1'b1; req1 = 1'b0; sel0 = 2'd0; sel1 = 2'd0; wdata0 = 8'h00; wdata1 = 8'h00;
        b_req0 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cs", 32'(cs), 32'hF);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check_eq("rst_done", 32'({done1, done0}), 32'd0);
        req0 = 1'b0;
        rst_i = 1'b0;
        last_m = 1;

        // Directed: A5 to slave 2, slave returns 3C.
        @(negedge clk);
        #1;
        sel0 = 2'd2; wdata0 = 8'hA5; req0 = 1'b1;
        run_xfer(1'b0, 8'h3C, waited);
        check_eq("dir_rdata", 32'(rdata), 32'h3C);

        // Reset during the 4th SCLK high phase.
        repeat (4) @(negedge clk);
        #1;
        sel0 = 2'd1; wdata0 = 8'($urandom); req0 = 1'b1;
        sl_tx = 8'($urandom);
        wait_gnt(who, waited, ok);
        check_eq("rst_test_gnt", 32'(ok), 32'd1);
        k = 0; rises = 0; prev = 1'b0;
        while (rises < 4 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
            if (k == 1) req0 = 1'b0;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        rst_i = 1'b1;
        #1;
        check_eq("abort_cs", 32'(cs), 32'hF);
        check_eq("abort_sclk", 32'(sclk), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        seen_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (done0 || done1) seen_done = 1'b1;
        end
        rst_i = 1'b0;
        last_m = 1;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done0 || done1) seen_done = 1'b1;
        end
        check_eq("abort_no_done", 32'(seen_done), 32'd0);

        // Both requests raised together and held: alternating grants, regrant right after GAP.
        sel0 = 2'($urandom); sel1 = 2'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'b1, 8'($urandom), waited);
            if (i > 0) check_eq("regrant_wait", 32'(waited), 32'(D));
        end
        req0 = 1'b0; req1 = 1'b0;

        // Random traffic; the loser of a tie stays pending with its data.
        for (int i = 0; i < 20; i++) begin
            if (!req0 && ($urandom_range(0, 1) == 1)) begin
                sel0 = 2'($urandom); wdata0 = 8'($urandom); req0 = 1'b1;
            end
            if (!req1 && ($urandom_range(0, 1) == 1)) begin
                sel1 = 2'($urandom); wdata1 = 8'($urandom); req1 = 1'b1;
            end
            if (!req0 && !req1) begin
                sel1 = 2'($urandom); wdata1 = 8'($urandom); req1 = 1'b1;
            end
            run_xfer(1'b0, 8'($urandom), waited);
        end
        for (int i = 0; i < 2 && (req0 || req1); i++) run_xfer(1'b0, 8'($urandom), waited);

        // CLK_DIV=1 instance, request held back-to-back.
        @(negedge clk);
        #1;
        b_req0 = 1'b1;
        #1;
        d1 = -1; d2 = -1; g2 = -1; gap = 0;
        check_eq("div1_gnt_first", 32'(b_gnt0), 32'd1);
        for (int s = 1; s < 60; s++) begin
            @(negedge clk);
            #1;
            if (b_done0 && d1 < 0) d1 = s;
            else if (b_done0 && d2 < 0) d2 = s;
            if (b_gnt0 && d1 >= 0 && g2 < 0) g2 = s;
            if (d1 >= 0 && g2 < 0 && b_cs == 4'hF) gap++;
        end
        b_req0 = 1'b0;
        check_eq("div1_lat1", 32'(d1), 32'd18);
        check_eq("div1_lat2", 32'(d2 - g2), 32'd18);
        check_eq("div1_cs_gap", 32'(gap >= 1), 32'd1);
        check_eq("div1_rdata", 32'(b_rdata), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning system clocks per SCLK half-period; the block SHALL support values 1..255.
REQ-002 Port clk_i  in  1  system clock; all state SHALL change on its rising edge.
REQ-003 Port rst_i  in  1  reset; reset SHALL be asynchronous and active-high.
REQ-004 Ports req0_i, req1_i  in  1 each  transfer requests from requester 0 and requester 1; each SHALL stay high until its grant.
REQ-005 Ports sel0_bi, sel1_bi  in  2 each  target slave index, valid while the matching req is high.
REQ-006 Ports wdata0_bi, wdata1_bi  in  8 each  byte to send, valid while the matching req is high.
REQ-007 Ports gnt0_o, gnt1_o  out  1 each  one-cycle pulse marking acceptance of the request; the arbiter SHALL capture sel and wdata in this cycle.
REQ-008 Ports done0_o, done1_o  out  1 each  one-cycle pulse marking completion of the granted transfer.
REQ-009 Port rdata_bo  out  8  byte received from MISO; SHALL be valid while any done is high and held until the next done.
REQ-010 Port busy_o  out  1  SHALL be high in every state except IDLE.
REQ-011 Ports spi_sclk_o  out  1  SPI clock (CPOL=0); spi_mosi_o  out  1  master data out; spi_miso_i  in  1  slave data in.
REQ-012 Port spi_cs_bo  out  4  active-low chip selects; at most one bit SHALL be low at any time.

Function
REQ-013 The SPI mode SHALL be CPOL=0, CPHA=0: data is shifted out LSB-first, and MOSI and MISO are both sampled on the rising edge of SCLK.
REQ-014 The FSM SHALL have the states IDLE, SETUP, SCLK_HI, SCLK_LO and GAP; a divider counter SHALL hold every non-IDLE state for exactly CLK_DIV cycles.
REQ-015 In IDLE with a pending req, the block SHALL pulse the winner's gnt, latch sel, wdata and the owner ID, and enter SETUP.
REQ-016 In SETUP the block SHALL drive spi_cs_bo[sel] low, SCLK 0 and spi_mosi_o = wdata[0].
REQ-017 On the SETUP->SCLK_HI and SCLK_LO->SCLK_HI transitions the block SHALL raise SCLK and shift rx <= {spi_miso_i, rx[7:1]}.
REQ-018 On the SCLK_HI->SCLK_LO transition the block SHALL lower SCLK and present the next tx bit on MOSI.
REQ-019 After the 8th SCLK_LO phase, CS SHALL still be low so the slave completes its final shift; the block SHALL then enter GAP.
REQ-020 On entry to GAP the block SHALL raise all CS bits, pulse the owner's done, update rdata_bo, and return to IDLE after CLK_DIV cycles.
REQ-021 Latency SHALL be exactly 17*CLK_DIV+1 cycles from the gnt cycle to the done cycle.
REQ-022 Arbitration SHALL be round-robin: with both reqs high, the requester not granted last wins; after reset, requester 0 has priority.
REQ-023 A req that falls after its gnt SHALL NOT affect the transfer; req is ignored outside IDLE.
REQ-024 A req held high across done SHALL be regranted at the earliest in the first IDLE cycle after GAP.

Reset
REQ-025 While rst_i is high, the block SHALL drive spi_cs_bo=4'b1111, SCLK=0, MOSI=0, rdata_bo=0, all gnt, done and busy outputs 0, state IDLE and round-robin pointer "last=1".
REQ-026 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done pulse.

Configuration
REQ-027 Macro SPI_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests; when undefined, the round-robin of REQ-022 applies.

Structure
REQ-028 A shared package spi_pkg SHALL hold the FSM state encoding, the slave count (4) and the word width (8).
REQ-029 The block SHALL contain one sub-module, spi_rr_arbiter (two-requester grant logic with the priority pointer), instantiated once.

Verification
REQ-030 With CLK_DIV=2, req0, sel0=2, wdata0=8'hA5 and the slave preloaded with 8'h3C: the bench SHALL see 8 SCLK pulses, only cs_bo[2] low, MOSI sequence 1,0,1,0,0,1,0,1, done0 exactly 35 cycles after gnt0, rdata_bo=8'h3C, and the slave's received byte = 8'hA5.
REQ-031 With req0 and req1 rising in the same cycle, held continuously: the grants SHALL be 0,1,0,1 with no overlapping CS.
REQ-032 With SPI_ARB_FIXED_PRIO_EN defined and both reqs held: every grant SHALL go to requester 0 until req0 drops.
REQ-033 With rst_i pulsed during the 4th SCLK_HI: cs_bo SHALL become 4'b1111 and SCLK 0 asynchronously, with no done; a subsequent transfer SHALL complete correctly.
REQ-034 With CLK_DIV=1 and back-to-back requests: each transfer SHALL take 18 cycles, and CS SHALL be high for at least 1 cycle between transfers.
